load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_byte_lane.sv | 22 ++
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared op codes, FSM encoding and address constants for the load/store unit.
// Also provides the request-legality helper used at accept time.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_SW  = 3'b100,
    OP_SB  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int unsigned WORD_SHIFT = 2;

  // Illegal op, or word access not aligned to a word boundary.
  function automatic logic req_err(
    input logic [2:0] op,
    input logic [1:0] lo
  );
    logic e;
    case (op)
      OP_LW, OP_SW:  e = (lo != 2'b00);
      OP_LB, OP_LBU,
      OP_SB:         e = 1'b0;
      default:       e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte extract (sign/zero extend) and byte merge on a 32-bit word.
// Ports: word_i, lane_i, sext_i, byte_i in; ext_o, merge_o out.
module lsu_byte_lane (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic        sext_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);

  logic [7:0] sel;

  // Little-endian lanes: lane k is bits [8k+7:8k].
  always_comb begin
    sel = word_i[{lane_i, 3'b000} +: 8];
    ext_o = {{24{sext_i & sel[7]}}, sel};
    merge_o = word_i;
    merge_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/READ/WRITE/RESP FSM between CPU and word memory.
// Ports: Clk, Reset, CPU req (i_Valid/i_Op/i_Addr/i_WData), resp, mem bus.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_Valid,
  input  logic [2:0]  i_Op,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WData,
  output logic        o_Ready,
  output logic        o_Done,
  output logic        o_Err,
  output logic [31:0] o_RData,
  output logic [31:0] o_A,
  output logic        o_WE,
  output logic [31:0] o_D,
  input  logic [31:0] i_D
);

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rword_q;
  logic        err_q;
  logic        accept;
  logic [31:0] ext;
  logic [31:0] merge;

  assign o_Ready = (state_q == S_IDLE) & ~Reset;
  assign accept  = i_Valid & o_Ready;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err(i_Op, i_Addr[1:0])) state_d = S_RESP;
          else if (i_Op == OP_SW)         state_d = S_WRITE;
          else                            state_d = S_READ;
        end
      end
      S_READ:  state_d = (op_q == OP_SB) ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= i_Op;
        addr_q  <= i_Addr;
        wdata_q <= i_WData;
        err_q   <= req_err(i_Op, i_Addr[1:0]);
      end
      if (state_q == S_READ) rword_q <= i_D;
    end
  end

  lsu_byte_lane u_lane (
    .word_i  (rword_q),
    .lane_i  (addr_q[1:0]),
    .sext_i  (op_q == OP_LB),
    .byte_i  (wdata_q[7:0]),
    .ext_o   (ext),
    .merge_o (merge)
  );

  always_comb begin
    o_Done  = 1'b0;
    o_Err   = 1'b0;
    o_RData = '0;
    o_A     = '0;
    o_WE    = 1'b0;
    o_D     = '0;
    unique case (state_q)
      S_READ: o_A = addr_q >> WORD_SHIFT;
      S_WRITE: begin
        o_A  = addr_q >> WORD_SHIFT;
        o_WE = 1'b1;
        o_D  = (op_q == OP_SB) ? merge : wdata_q;
      end
      S_RESP: begin
        o_Done = 1'b1;
        o_Err  = err_q;
        if (!err_q) begin
          case (op_q)
            OP_LW:         o_RData = rword_q;
            OP_LB, OP_LBU: o_RData = ext;
            default:       o_RData = '0;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory model.
// Directed vectors push expectations; a monitor pops on o_WE / o_Done.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        i_Valid = 1'b0;
  logic [2:0]  i_Op = '0;
  logic [31:0] i_Addr = '0;
  logic [31:0] i_WData = '0;
  logic        o_Ready, o_Done, o_Err, o_WE;
  logic [31:0] o_RData, o_A, o_D, i_D;

  logic [31:0] mem [0:63] = '{default: 32'h0};

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } done_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] d;
    int          acc;
    int          lat;
  } we_t;

  done_t dq[$];
  we_t   wq[$];

  load_store_unit dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_Valid (i_Valid),
    .i_Op    (i_Op),
    .i_Addr  (i_Addr),
    .i_WData (i_WData),
    .o_Ready (o_Ready),
    .o_Done  (o_Done),
    .o_Err   (o_Err),
    .o_RData (o_RData),
    .o_A     (o_A),
    .o_WE    (o_WE),
    .o_D     (o_D),
    .i_D     (i_D)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  assign i_D = mem[o_A[5:0]];

  always @(posedge Clk) begin
    if (o_WE) mem[o_A[5:0]] <= o_D;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic monitor();
    we_t   w;
    done_t d;
    forever begin
      @(negedge Clk);
      if (o_WE === 1'b1) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we: got o_WE=1 (A=%h) want 0", o_A);
        end else begin
          w = wq.pop_front();
          chk({w.name, "_we_addr"}, o_A, w.a);
          chk({w.name, "_we_data"}, o_D, w.d);
          chk({w.name, "_we_lat"}, 32'(cyc - w.acc), 32'(w.lat));
        end
      end
      if (o_Done === 1'b1) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got o_Done=1 want 0");
        end else begin
          d = dq.pop_front();
          chk({d.name, "_rdata"}, o_RData, d.rdata);
          chk({d.name, "_err"}, 32'(o_Err), 32'(d.err));
          chk({d.name, "_lat"}, 32'(cyc - d.acc), 32'(d.lat));
        end
      end
    end
  endtask

  task automatic issue(
    input string       name,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input logic        err,
    input int          dlat,
    input logic        has_we,
    input logic [31:0] wa,
    input logic [31:0] wdat,
    input int          wlat
  );
    int n;
    int acc;
    n = 0;
    @(negedge Clk);
    i_Op    = op;
    i_Addr  = addr;
    i_WData = wd;
    i_Valid = 1'b1;
    while (o_Ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (o_Ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got o_Ready=%b want 1", name, o_Ready);
      i_Valid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    acc = cyc - 1;
    i_Valid = 1'b0;
    dq.push_back('{name: name, rdata: rd, err: err, acc: acc, lat: dlat});
    if (has_we)
      wq.push_back('{name: name, a: wa, d: wdat, acc: acc, lat: wlat});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((dq.size() != 0 || wq.size() != 0) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (dq.size() != 0 || wq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               dq.size() + wq.size());
      dq.delete();
      wq.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    fork
      monitor();
    join_none

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("ready_in_reset", 32'(o_Ready), 32'h0);
    Reset = 1'b0;
    #1;
    chk("rst_ready", 32'(o_Ready), 32'h1);
    chk("rst_done",  32'(o_Done),  32'h0);
    chk("rst_err",   32'(o_Err),   32'h0);
    chk("rst_rdata", o_RData,      32'h0);
    chk("rst_we",    32'(o_WE),    32'h0);
    chk("rst_a",     o_A,          32'h0);
    chk("rst_d",     o_D,          32'h0);

    // name, op, addr, wdata, rdata, err, dlat, we?, wa, wd, wlat
    issue("sw40",  3'b100, 32'h40, 32'hDEADBEEF, 32'h0,        0, 2,
          1, 32'h10, 32'hDEADBEEF, 1);
    issue("lb43",  3'b001, 32'h43, 32'h0, 32'hFFFFFFDE, 0, 2, 0, 0, 0, 0);
    issue("lbu43", 3'b010, 32'h43, 32'h0, 32'h000000DE, 0, 2, 0, 0, 0, 0);
    issue("lw40",  3'b000, 32'h40, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0, 0, 0);
    issue("lb40",  3'b001, 32'h40, 32'h0, 32'hFFFFFFEF, 0, 2, 0, 0, 0, 0);
    issue("sb41",  3'b101, 32'h41, 32'h55, 32'h0,       0, 3,
          1, 32'h10, 32'hDEAD55EF, 2);
    issue("lw40b", 3'b000, 32'h40, 32'h0, 32'hDEAD55EF, 0, 2, 0, 0, 0, 0);
    issue("lbu41", 3'b010, 32'h41, 32'h0, 32'h00000055, 0, 2, 0, 0, 0, 0);
    issue("lb41",  3'b001, 32'h41, 32'h0, 32'h00000055, 0, 2, 0, 0, 0, 0);

    issue("lw42",  3'b000, 32'h42, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0);
    issue("op011", 3'b011, 32'h40, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0);
    issue("sw41",  3'b100, 32'h41, 32'h11111111, 32'h0, 1, 1, 0, 0, 0, 0);
    issue("op111", 3'b111, 32'h44, 32'h22222222, 32'h0, 1, 1, 0, 0, 0, 0);

    issue("sw44",  3'b100, 32'h44, 32'h12345678, 32'h0, 0, 2,
          1, 32'h11, 32'h12345678, 1);
    issue("sb47",  3'b101, 32'h47, 32'hABCDEF80, 32'h0, 0, 3,
          1, 32'h11, 32'h80345678, 2);
    issue("lb47",  3'b001, 32'h47, 32'h0, 32'hFFFFFF80, 0, 2, 0, 0, 0, 0);
    issue("lbu44", 3'b010, 32'h44, 32'h0, 32'h00000078, 0, 2, 0, 0, 0, 0);
    issue("lw44",  3'b000, 32'h44, 32'h0, 32'h80345678, 0, 2, 0, 0, 0, 0);
    wait_drain();

    // Reset while an SB sits in READ: it must vanish without a write.
    @(negedge Clk);
    i_Op    = 3'b101;
    i_Addr  = 32'h41;
    i_WData = 32'hAA;
    i_Valid = 1'b1;
    @(posedge Clk);
    #1;
    i_Valid = 1'b0;
    Reset   = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("rst_mid_ready", 32'(o_Ready), 32'h0);
    chk("rst_mid_we",    32'(o_WE),    32'h0);
    Reset = 1'b0;
    #1;
    chk("rst_mid_ready_after", 32'(o_Ready), 32'h1);
    repeat (5) @(negedge Clk);
    chk("rst_mid_mem", mem[16], 32'hDEAD55EF);
    issue("lw40_post_rst", 3'b000, 32'h40, 32'h0, 32'hDEAD55EF, 0, 2,
          0, 0, 0, 0);
    wait_drain();

    // i_Valid held high: only IDLE cycles accept (one every 3 edges).
    @(negedge Clk);
    i_Op    = 3'b000;
    i_Addr  = 32'h40;
    i_WData = 32'h0;
    i_Valid = 1'b1;
    @(posedge Clk);
    #1;
    base = cyc - 1;
    for (int k = 0; k < 3; k++)
      dq.push_back('{name: $sformatf("b2b%0d", k), rdata: 32'hDEAD55EF,
                     err: 1'b0, acc: base + 3 * k, lat: 2});
    repeat (8) @(posedge Clk);
    #1;
    i_Valid = 1'b0;
    repeat (6) @(negedge Clk);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
